calculator_main: RTL and testbench

- Top level of an RPN (stack) integer calculator board.
- Scans a 4x4 keypad, applies digit-entry and stack operations to a signed stack, and drives an 8-digit multiplexed 7-segment display.
- Display shows the top of stack (decimal or hex), the stack depth, or "Error".
- Internal hierarchy is fixed for white-box checks: instance `stack` exposes `top`, `next`, `count`; instance `numpad` exposes `is_alt`.

---
 rtl/calculator_main.sv | 391 +++++++++++++++++++++++++++++++++++++++
 tb/tb_calculator_main.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calculator_main.sv
// RPN integer calculator: keypad scanner, signed stack, 8-digit 7-segment display.
// Optional macro KEY_DEBOUNCE_EN: accept keys only after 4 stable full scans.

package calculator_pkg;
    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD, OP_PUSH, OP_POP, OP_SWAP, OP_REDUCE
    } stack_op_t;
endpackage

module calculator_stack
    import calculator_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 16,
    parameter int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  stack_op_t               op,
    input  logic signed [WIDTH-1:0] value,
    output logic signed [WIDTH-1:0] top,
    output logic signed [WIDTH-1:0] next,
    output logic [CW-1:0]           count
);
    localparam int LOW = STACK_DEPTH - 2;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

    // Entries below top/next, index 0 is the one just under next.
    logic signed [WIDTH-1:0] below [LOW];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            top   <= '0;
            next  <= '0;
            count <= ONE;
            for (int i = 0; i < LOW; i++) below[i] <= '0;
        end else begin
            case (op)
                OP_LOAD: top <= value;
                OP_PUSH: if (count != FULL) begin
                    top      <= '0;
                    next     <= top;
                    below[0] <= next;
                    for (int i = 1; i < LOW; i++) below[i] <= below[i-1];
                    count    <= count + ONE;
                end
                OP_POP, OP_REDUCE: begin
                    if (op == OP_REDUCE) top <= value;
                    else if (count == ONE) top <= '0;
                    else top <= next;
                    next <= below[0];
                    for (int i = 0; i < LOW - 1; i++) below[i] <= below[i+1];
                    below[LOW-1] <= '0;
                    if (count != ONE) count <= count - ONE;
                end
                OP_SWAP: begin
                    top  <= next;
                    next <= top;
                end
                default: ;
            endcase
        end
    end
endmodule

module calculator_numpad #(
    parameter int SCAN_DIV = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic       alt_key,
    output logic [3:0] columns,
    output logic       key_event,
    output logic [3:0] key_code,
    output logic       is_alt
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div;
    logic [1:0]    col;
    logic [3:0]    rows_s1, rows_s2;
    logic [2:0]    alt_sync;
    logic          hit;
    logic [3:0]    hit_code;
    logic [4:0]    accepted;
    logic [4:0]    scan_key;
    logic [1:0]    row;
    logic [3:0]    code;
    logic          step, scan_done, row_any, accept;

    function automatic logic [3:0] keymap(input logic [1:0] c, input logic [1:0] r);
        case ({c, r})
            4'h0: keymap = 4'h1;  4'h1: keymap = 4'h4;
            4'h2: keymap = 4'h7;  4'h3: keymap = 4'h0;
            4'h4: keymap = 4'h2;  4'h5: keymap = 4'h5;
            4'h6: keymap = 4'h8;  4'h7: keymap = 4'hF;
            4'h8: keymap = 4'h3;  4'h9: keymap = 4'h6;
            4'hA: keymap = 4'h9;  4'hB: keymap = 4'hE;
            4'hC: keymap = 4'hA;  4'hD: keymap = 4'hB;
            4'hE: keymap = 4'hC;  default: keymap = 4'hD;
        endcase
    endfunction

    assign columns   = ~(4'b0001 << col);
    assign step      = (div == DW'(SCAN_DIV - 1));
    assign scan_done = step && (col == 2'd3);
    assign row_any   = (rows_s2 != 4'hF);
    assign code      = keymap(col, row);

    always_comb begin
        row = 2'd0;
        for (int r = 3; r >= 0; r--)
            if (!rows_s2[r]) row = 2'(r);
    end

    // First key found during the scan wins; the last column is folded in here.
    always_comb begin
        scan_key = 5'd0;
        if (hit) scan_key = {1'b1, hit_code};
        else if (row_any) scan_key = {1'b1, code};
    end

`ifdef KEY_DEBOUNCE_EN
    logic [4:0] cand;
    logic [2:0] stable;

    assign accept = (scan_key == cand) && (stable == 3'd3);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cand   <= 5'd0;
            stable <= 3'd4;
        end else if (scan_done) begin
            if (scan_key != cand) begin
                cand   <= scan_key;
                stable <= 3'd1;
            end else if (stable != 3'd4) begin
                stable <= stable + 3'd1;
            end
        end
    end
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div       <= '0;
            col       <= 2'd0;
            rows_s1   <= 4'hF;
            rows_s2   <= 4'hF;
            hit       <= 1'b0;
            hit_code  <= 4'd0;
            accepted  <= 5'd0;
            key_event <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            rows_s1   <= rows;
            rows_s2   <= rows_s1;
            key_event <= 1'b0;
            if (step) begin
                div <= '0;
                col <= col + 2'd1;
            end else begin
                div <= div + 1'b1;
            end
            if (step && !scan_done && row_any && !hit) begin
                hit      <= 1'b1;
                hit_code <= code;
            end
            if (scan_done) begin
                hit <= 1'b0;
                if (accept) begin
                    accepted  <= scan_key;
                    key_event <= scan_key[4] && (scan_key != accepted);
                    key_code  <= scan_key[3:0];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alt_sync <= 3'b111;
            is_alt   <= 1'b0;
        end else begin
            alt_sync <= {alt_sync[1:0], alt_key};
            if (key_event) is_alt <= 1'b0;
            else if (alt_sync[2] && !alt_sync[1]) is_alt <= ~is_alt;
        end
    end
endmodule

module calculator_main
    import calculator_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 16,
    parameter int SCAN_DIV    = 1024,
    parameter int DISP_DIV    = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       show_in_hex,
    input  logic       show_count,
    input  logic       alt_numpad_key,
    output logic       alt_numpad_led,
    input  logic [3:0] numpad_rows,
    output logic [3:0] numpad_columns,
    output logic [7:0] display_leds,
    output logic [7:0] display_control
);
    localparam int CW   = $clog2(STACK_DEPTH + 1);
    localparam int DECD = (WIDTH * 3) / 10 + 1;
    localparam int BW   = $clog2(WIDTH + 1);
    localparam int PW   = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic signed [WIDTH-1:0] LIMIT = WIDTH'(10_000_000);
    localparam logic signed [WIDTH-1:0] TEN   = WIDTH'(10);
    localparam logic signed [WIDTH-1:0] INC   = WIDTH'(1);
    localparam logic signed [WIDTH-1:0] M_ONE = -INC;

    stack_op_t               op;
    logic signed [WIDTH-1:0] value, top, next, digit;
    logic [CW-1:0]           count;
    logic                    key_event, is_alt, error, div_zero;
    logic [3:0]              key_code;

    calculator_numpad #(.SCAN_DIV(SCAN_DIV)) numpad (
        .clock(clock), .reset(reset), .rows(numpad_rows),
        .alt_key(alt_numpad_key), .columns(numpad_columns),
        .key_event(key_event), .key_code(key_code), .is_alt(is_alt)
    );

    calculator_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) stack (
        .clock(clock), .reset(reset), .op(op), .value(value),
        .top(top), .next(next), .count(count)
    );

    assign alt_numpad_led = ~is_alt;
    assign digit = signed'(WIDTH'(key_code));

    always_comb begin
        op       = OP_NOP;
        value    = top;
        div_zero = 1'b0;
        if (key_event && !error) begin
            if (is_alt) begin
                case (key_code)
                    4'h1, 4'h2, 4'h3, 4'hA: if (count != ONE) begin
                        op = OP_REDUCE;
                        case (key_code)
                            4'h1: value = next + top;
                            4'h2: value = next - top;
                            4'h3: value = next * top;
                            default: value = (top == M_ONE) ? -next : next / top;
                        endcase
                        if (key_code == 4'hA && top == '0) begin
                            op       = OP_NOP;
                            div_zero = 1'b1;
                        end
                    end
                    4'h6: begin op = OP_LOAD; value = top + INC; end
                    4'hB: begin op = OP_LOAD; value = top - INC; end
                    4'h4: begin op = OP_LOAD; value = top * top; end
                    4'h5: begin op = OP_LOAD; value = top * top * top; end
                    default: ;
                endcase
            end else begin
                case (key_code)
                    4'hA: begin op = OP_LOAD; value = top / TEN; end
                    4'hB: op = OP_PUSH;
                    4'hC: op = OP_POP;
                    4'hD: op = OP_SWAP;
                    4'hE: begin op = OP_LOAD; value = '0; end
                    4'hF: begin op = OP_LOAD; value = -top; end
                    default: if (top < LIMIT && top > -LIMIT) begin
                        op    = OP_LOAD;
                        value = top * TEN + ((top < 0) ? -digit : digit);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) error <= 1'b0;
        else if (div_zero) error <= 1'b1;
    end

    logic signed [WIDTH-1:0] disp_value;
    logic [WIDTH-1:0]        disp_mag, bin_sh;
    logic                    disp_neg, hex;
    logic [4*DECD-1:0]       bcd, bcd_acc, bcd_adj;
    logic [BW-1:0]           bit_cnt;

    assign hex        = show_in_hex && !show_count;
    assign disp_value = show_count ? signed'(WIDTH'(count)) : top;
    assign disp_neg   = disp_value < 0;
    assign disp_mag   = disp_neg ? unsigned'(-disp_value) : unsigned'(disp_value);

    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < DECD; i++)
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end

    // Free-running double-dabble; a fresh BCD image lands every WIDTH+1 cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcd     <= '0;
            bcd_acc <= '0;
            bin_sh  <= '0;
            bit_cnt <= '0;
        end else if (bit_cnt == '0) begin
            bcd     <= bcd_acc;
            bcd_acc <= '0;
            bin_sh  <= disp_mag;
            bit_cnt <= BW'(WIDTH);
        end else begin
            bcd_acc <= {bcd_adj[4*DECD-2:0], bin_sh[WIDTH-1]};
            bin_sh  <= bin_sh << 1;
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'h3F;  4'h1: seg7 = 8'h06;
            4'h2: seg7 = 8'h5B;  4'h3: seg7 = 8'h4F;
            4'h4: seg7 = 8'h66;  4'h5: seg7 = 8'h6D;
            4'h6: seg7 = 8'h7D;  4'h7: seg7 = 8'h07;
            4'h8: seg7 = 8'h7F;  4'h9: seg7 = 8'h6F;
            4'hA: seg7 = 8'h77;  4'hB: seg7 = 8'h7C;
            4'hC: seg7 = 8'h58;  4'hD: seg7 = 8'h5E;
            4'hE: seg7 = 8'h79;  default: seg7 = 8'h71;
        endcase
    endfunction

    logic [31:0]   digit_vec;
    logic [7:0]    shown, seg;
    logic [2:0]    digit_idx;
    logic [PW-1:0] disp_div;

    assign digit_vec = hex ? 32'(disp_mag) : 32'(bcd);

    // A digit is lit if it or any more significant digit is non-zero.
    always_comb begin
        logic nz;
        nz    = 1'b0;
        shown = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            nz       = nz | (digit_vec[4*i +: 4] != 4'd0);
            shown[i] = nz || (i == 0);
        end
    end

    always_comb begin
        seg = 8'h00;
        if (error) begin
            case (digit_idx)
                3'd4: seg = 8'h79;
                3'd3, 3'd2, 3'd0: seg = 8'h50;
                3'd1: seg = 8'h5C;
                default: seg = 8'h00;
            endcase
        end else if (digit_idx == 3'd7 && disp_neg) begin
            seg = 8'h40;
        end else if (shown[digit_idx]) begin
            seg = seg7(digit_vec[{digit_idx, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_div  <= '0;
            digit_idx <= 3'd0;
        end else if (disp_div == PW'(DISP_DIV - 1)) begin
            disp_div  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            disp_div <= disp_div + 1'b1;
        end
    end

    assign display_leds    = ~seg;
    assign display_control = ~(8'b1 << digit_idx);
endmodule

// File: tb/tb_calculator_main.sv
// Directed bench for calculator_main: keypad model, state scoreboard,
// and decoding of the multiplexed display.
module tb_calculator_main;
    localparam int SCAN   = 8;
    localparam int DISP   = 4;
    localparam int SETTLE = 10 * 4 * SCAN;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       show_in_hex = 1'b0;
    logic       show_count = 1'b0;
    logic       alt_numpad_key = 1'b1;
    logic       alt_numpad_led;
    logic [3:0] numpad_rows, numpad_columns;
    logic [7:0] display_leds, display_control;

    int checks = 0;
    int errors = 0;

    logic key_down = 1'b0;
    int   key_r = 0;
    int   key_c = 0;
    int   key_row [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int   key_col [16] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 1};

    typedef struct {
        logic signed [31:0] top;
        logic signed [31:0] next;
        int                 count;
    } exp_t;
    exp_t sb[$];

    calculator_main #(
        .WIDTH(32), .STACK_DEPTH(16), .SCAN_DIV(SCAN), .DISP_DIV(DISP)
    ) dut (
        .clock(clock), .reset(reset),
        .show_in_hex(show_in_hex), .show_count(show_count),
        .alt_numpad_key(alt_numpad_key), .alt_numpad_led(alt_numpad_led),
        .numpad_rows(numpad_rows), .numpad_columns(numpad_columns),
        .display_leds(display_leds), .display_control(display_control)
    );

    always #5 clock = ~clock;

    // A pressed key connects its row to its column.
    always_comb begin
        numpad_rows = 4'hF;
        if (key_down && !numpad_columns[key_c]) numpad_rows[key_r] = 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input byte ch);
        case (ch)
            "0": seg_of = 8'h3F;  "1": seg_of = 8'h06;
            "2": seg_of = 8'h5B;  "3": seg_of = 8'h4F;
            "4": seg_of = 8'h66;  "5": seg_of = 8'h6D;
            "6": seg_of = 8'h7D;  "7": seg_of = 8'h07;
            "8": seg_of = 8'h7F;  "9": seg_of = 8'h6F;
            "A": seg_of = 8'h77;  "b": seg_of = 8'h7C;
            "c": seg_of = 8'h58;  "d": seg_of = 8'h5E;
            "E": seg_of = 8'h79;  "F": seg_of = 8'h71;
            "r": seg_of = 8'h50;  "o": seg_of = 8'h5C;
            "-": seg_of = 8'h40;  default: seg_of = 8'h00;
        endcase
    endfunction

    // Leftmost character is digit 7.
    function automatic logic [63:0] text(input string s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = seg_of(s[i]);
        return r;
    endfunction

    task automatic check_display(input string tag, input string s);
        logic [63:0] segs;
        logic [7:0]  seen;
        segs = '0;
        seen = '0;
        repeat (40) @(negedge clock);
        for (int n = 0; n < 8 * DISP * 3; n++) begin
            @(negedge clock);
            for (int d = 0; d < 8; d++)
                if (display_control == ~(8'b1 << d)) begin
                    segs[8*d +: 8] = ~display_leds;
                    seen[d] = 1'b1;
                end
        end
        check({tag, " scan"}, 64'(seen), 64'hFF);
        check(tag, segs, text(s));
    endtask

    task automatic check_state(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, " top"}, 64'(dut.stack.top), 64'(e.top));
        check({tag, " count"}, 64'(dut.stack.count), 64'(e.count));
        if (e.count > 1) check({tag, " next"}, 64'(dut.stack.next), 64'(e.next));
    endtask

    task automatic press(input int code);
        key_r = key_row[code];
        key_c = key_col[code];
        key_down = 1'b1;
        repeat (SETTLE) @(negedge clock);
        key_down = 1'b0;
        repeat (SETTLE) @(negedge clock);
    endtask

    task automatic key(input int code, input int t, input int n, input int c, input string tag);
        exp_t e;
        e.top = t;
        e.next = n;
        e.count = c;
        sb.push_back(e);
        press(code);
        check_state(tag);
    endtask

    task automatic alt_tap();
        alt_numpad_key = 1'b0;
        repeat (10) @(negedge clock);
        alt_numpad_key = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic akey(input int code, input int t, input int n, input int c, input string tag);
        alt_tap();
        check({tag, " led armed"}, 64'(alt_numpad_led), 64'd0);
        key(code, t, n, c, tag);
        check({tag, " led clear"}, 64'(alt_numpad_led), 64'd1);
    endtask

    task automatic do_reset();
        exp_t e;
        reset = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        e.top = 0;
        e.next = 0;
        e.count = 1;
        sb.push_back(e);
        check_state("reset");
    endtask

    initial begin
        do_reset();
        check("reset is_alt", 64'(dut.numpad.is_alt), 64'd0);
        check("reset led", 64'(alt_numpad_led), 64'd1);
        check_display("reset disp", "       0");
        show_count = 1'b1;
        check_display("count disp", "       1");
        show_count = 1'b0;

        key(1, 1, 0, 1, "k1");
        key(2, 12, 0, 1, "k2");
        key(3, 123, 0, 1, "k3");
        check_display("dec 123", "     123");
        show_in_hex = 1'b1;
        check_display("hex 7b", "      7b");

        key(11, 0, 123, 2, "push");
        key(9, 9, 123, 2, "k9");
        key(0, 90, 123, 2, "k0a");
        key(0, 900, 123, 2, "k0b");
        show_count = 1'b1;
        check_display("count prio", "       2");
        show_count = 1'b0;

        alt_tap();
        check("alt is_alt", 64'(dut.numpad.is_alt), 64'd1);
        check("alt led", 64'(alt_numpad_led), 64'd0);
        key(1, 1023, 0, 1, "add");
        check("add led", 64'(alt_numpad_led), 64'd1);
        check_display("hex 3FF", "     3FF");
        show_in_hex = 1'b0;

        key(11, 0, 1023, 2, "push s");
        key(8, 8, 1023, 2, "k8 s");
        akey(2, 1015, 0, 1, "sub");
        key(11, 0, 1015, 2, "push m");
        key(7, 7, 1015, 2, "k7 m");
        akey(3, 7105, 0, 1, "mul");
        key(11, 0, 7105, 2, "push d");
        key(6, 6, 7105, 2, "k6 d");
        akey(10, 1184, 0, 1, "div");
        key(15, -1184, 0, 1, "neg");
        check_display("neg disp", "-   1184");
        key(11, 0, -1184, 2, "push n");
        key(5, 5, -1184, 2, "k5 n");
        key(15, -5, -1184, 2, "neg5");
        akey(10, 236, 0, 1, "div neg");

        key(10, 23, 0, 1, "div10");
        key(14, 0, 0, 1, "clear");
        key(7, 7, 0, 1, "k7");
        key(11, 0, 7, 2, "push 7");
        key(8, 8, 7, 2, "k8");
        key(13, 7, 8, 2, "swap");
        key(12, 8, 0, 1, "pop");

        akey(6, 9, 0, 1, "inc");
        akey(11, 8, 0, 1, "dec");
        akey(4, 64, 0, 1, "square");
        akey(5, 262144, 0, 1, "cube");
        check_display("cube disp", "  262144");

        key(11, 0, 262144, 2, "push z");
        akey(10, 0, 262144, 2, "div0");
        check_display("err disp", "   Error");
        key(5, 0, 262144, 2, "err ignore");

        do_reset();
        check_display("reset2 disp", "       0");

        key(1, 1, 0, 1, "l1");
        key(2, 12, 0, 1, "l2");
        key(3, 123, 0, 1, "l3");
        key(4, 1234, 0, 1, "l4");
        key(5, 12345, 0, 1, "l5");
        key(6, 123456, 0, 1, "l6");
        key(7, 1234567, 0, 1, "l7");
        key(8, 12345678, 0, 1, "l8");
        key(9, 12345678, 0, 1, "limit");
        check_display("8 digits", "12345678");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
